camera_window_packer: RTL
=========================

CAMERA_WINDOW_PACKER -- requirements
Module: camera_window_packer

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- X_START, 0, first byte column inside the window.
- X_LEN, 640, window width in bytes; must be a multiple of 4 and at least 4.
- Y_START, 0, first line inside the window.
- Y_LEN, 480, window height in lines; at least 1.
- FIFO_DEPTH, 16, output FIFO depth in 32-bit words; a power of 2 and at least 2.

REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- pixclk_i, input, 1, the only clock; every register is clocked on its rising edge.
- rst_i, input, 1, reset; synchronous and active-high.
- pix_valid_i, input, 1, pix_data_i carries one byte this cycle.
- pix_data_i, input, 8, pixel byte.
- frame_start_i, input, 1, with pix_valid_i: this byte is column 0 of line 0.
- line_end_i, input, 1, with pix_valid_i: this byte is the last byte of its line.
- word_o, output, 32, packed word; the earliest byte is in bits [7:0].
- word_valid_o, output, 1, word_o and its flags are valid.
- word_ready_i, input, 1, the consumer accepts the word this cycle.
- word_sof_o, output, 1, this word is the first word of the window.
- word_eol_o, output, 1, this word is the last word of a window line.
- overflow_o, output, 1, sticky: a completed word was dropped.
- frame_done_o, output, 1, one-cycle pulse after the last window word is pushed.

Function
REQ-003 The block SHALL sample frame_start_i, line_end_i and pix_data_i only in cycles where pix_valid_i=1.
REQ-004 The block SHALL keep a byte column counter x and a line counter y, each 16 bits wide.
- frame_start_i sets x=0 and y=0 for the current byte.
- Each other accepted byte increments x.
- line_end_i causes the next byte to use x=0 and y+1.
- y saturates at 16'hFFFF.
REQ-005 A byte SHALL be in the window when X_START<=x<X_START+X_LEN and Y_START<=y<Y_START+Y_LEN.
REQ-006 The block SHALL pack window bytes into a 32-bit word in arrival order; the word completes on its 4th byte.
REQ-007 If line_end_i arrives on an in-window byte with a partial word pending, the block SHALL zero-fill the upper bytes, complete that word, and set its eol flag.
REQ-008 The eol flag SHALL also be set on the word holding byte x=X_START+X_LEN-1; the sof flag SHALL be set on the word holding the first window byte.
REQ-009 The block SHALL have three states: IDLE, ACTIVE and DROP.
- IDLE -> ACTIVE on frame_start_i.
- ACTIVE -> IDLE after the last window word is pushed; frame_done_o pulses in the next cycle.
- ACTIVE -> DROP on overflow.
- DROP -> ACTIVE on frame_start_i.
- In IDLE and DROP, bytes are ignored except for frame_start_i.
REQ-010 When frame_start_i arrives in ACTIVE, the block SHALL discard any partial word and restart the frame with no other side effect.
REQ-011 A completed word SHALL be pushed in the cycle after its last byte, or after line_end_i for a partial word.
- The push succeeds if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
- Otherwise the word is dropped, overflow_o is set, and the state moves to DROP.
REQ-012 Output handshake rules:
- A pop occurs when word_valid_o=1 and word_ready_i=1.
- word_o and its flags SHALL hold stable while word_valid_o=1 and word_ready_i=0.
- word_valid_o SHALL equal "FIFO not empty".
- Latency: the 4th byte in cycle N gives word_valid_o=1 in cycle N+1 when the FIFO was empty.
- A simultaneous push and pop with the FIFO empty SHALL be impossible; push-then-pop ordering applies.
REQ-013 The FIFO SHALL use wrap-around read and write pointers with one extra MSB to tell full from empty; its occupancy SHALL never exceed FIFO_DEPTH.
REQ-014 overflow_o SHALL stay set until reset; a new frame SHALL NOT clear it.

Reset
REQ-015 While rst_i=1 at a clock edge, the block SHALL go to state IDLE and clear counters, the partial word and both FIFO pointers.
REQ-016 Output values in reset: word_valid_o=0, word_sof_o=0, word_eol_o=0, overflow_o=0, frame_done_o=0 and word_o=0.
REQ-017 A reset asserted mid-frame SHALL discard all buffered words; the block SHALL ignore bytes until the next frame_start_i.

Verification
Scenarios use X_START=2, X_LEN=4, Y_START=1, Y_LEN=2 and FIFO_DEPTH=2 unless stated.
REQ-018 Basic window:
- Stimulus: 3 lines of 8 bytes, values 0x00..0x17, with word_ready_i=1.
- Response: words 0x0D0C0B0A (sof=1, eol=1) then 0x15141312 (eol=1), then one frame_done_o pulse.
REQ-019 Backpressure:
- Stimulus: as in REQ-018, with word_ready_i=0 until both words are queued, then 1.
- Response: word_o holds 0x0D0C0B0A until it is accepted; overflow_o stays 0.
REQ-020 Overflow:
- Stimulus: FIFO_DEPTH=2, X_LEN=4, Y_LEN=3, word_ready_i=0.
- Response: the 3rd word is dropped and overflow_o=1; the remaining frame is ignored; the next frame is packed again and overflow_o stays 1.
REQ-021 Short line:
- Stimulus: line 1 ends at x=3 (line_end_i on byte 0x0B).
- Response: word 0x00000B0A with eol=1.
REQ-022 Restart and reset:
- Stimulus 1: frame_start_i after 2 window bytes of line 1.
- Response 1: the partial word is discarded and the new frame packs correctly.
- Stimulus 2: rst_i=1 for 1 cycle with 1 word queued.
- Response 2: word_valid_o=0 in the next cycle and all outputs are zero.

Source files
------------

// File: rtl/camera_window_packer.sv
// Camera byte-stream window extractor: keeps bytes inside a rectangular window,
// packs them little-endian into 32-bit words and queues them in a small FIFO.
module camera_window_packer #(
  parameter int unsigned X_START    = 0,
  parameter int unsigned X_LEN      = 640,
  parameter int unsigned Y_START    = 0,
  parameter int unsigned Y_LEN      = 480,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        pixclk_i,
  input  logic        rst_i,
  input  logic        pix_valid_i,
  input  logic [7:0]  pix_data_i,
  input  logic        frame_start_i,
  input  logic        line_end_i,
  output logic [31:0] word_o,
  output logic        word_valid_o,
  input  logic        word_ready_i,
  output logic        word_sof_o,
  output logic        word_eol_o,
  output logic        overflow_o,
  output logic        frame_done_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StActive, StDrop} state_e;

  state_e        state_q, state_d;
  logic [15:0]   x_q, x_d, y_q, y_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [23:0]   pack_q, pack_d;
  logic          psof_q, psof_d;
  logic          first_q, first_d;
  logic          overflow_q, overflow_d;
  logic          done_q, done_d;
  logic [PtrW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [33:0]   mem_q [FIFO_DEPTH];
  logic [33:0]   rd_entry;

  logic          take, in_win, last_col, complete, push_ok, pop, full, empty;
  logic [15:0]   cur_x, cur_y;
  logic [1:0]    cur_cnt;
  logic [23:0]   cur_pack;
  logic          cur_psof, cur_first;
  logic [31:0]   word;
  logic          w_sof, w_eol, w_last;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                 (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign pop   = !empty && word_ready_i;

  // Byte decode, packing and next-state logic
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    cnt_d      = cnt_q;
    pack_d     = pack_q;
    psof_d     = psof_q;
    first_d    = first_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;

    // A frame start byte is taken in any state and restarts position/packing
    take      = pix_valid_i && (frame_start_i || state_q == StActive);
    cur_x     = frame_start_i ? 16'h0 : x_q;
    cur_y     = frame_start_i ? 16'h0 : y_q;
    cur_cnt   = frame_start_i ? 2'd0 : cnt_q;
    cur_pack  = frame_start_i ? 24'h0 : pack_q;
    cur_psof  = frame_start_i ? 1'b0 : psof_q;
    cur_first = frame_start_i ? 1'b1 : first_q;

    // Unsigned wrap makes positions left/above the window fail the length test
    in_win   = take && (({16'h0, cur_x} - X_START) < X_LEN) &&
               (({16'h0, cur_y} - Y_START) < Y_LEN);
    last_col = (({16'h0, cur_x} - X_START) == X_LEN - 32'd1);

    word = {8'h0, cur_pack};
    word[{cur_cnt, 3'b000} +: 8] = pix_data_i;
    w_sof    = cur_psof || cur_first;
    w_eol    = line_end_i || last_col;
    w_last   = w_eol && (({16'h0, cur_y} - Y_START) == Y_LEN - 32'd1);
    complete = in_win && (cur_cnt == 2'd3 || w_eol);
    push_ok  = complete && (!full || pop);

    if (take) begin
      x_d     = line_end_i ? 16'h0 : cur_x + 16'd1;
      y_d     = (line_end_i && cur_y != 16'hFFFF) ? cur_y + 16'd1 : cur_y;
      cnt_d   = cur_cnt;
      pack_d  = cur_pack;
      psof_d  = cur_psof;
      first_d = cur_first;
      if (in_win) begin
        first_d = 1'b0;
        if (complete) begin
          cnt_d  = 2'd0;
          pack_d = 24'h0;
          psof_d = 1'b0;
        end else begin
          cnt_d  = cur_cnt + 2'd1;
          pack_d = word[23:0];
          psof_d = w_sof;
        end
      end
    end

    if (pix_valid_i && frame_start_i) state_d = StActive;
    if (complete && !push_ok) begin
      state_d    = StDrop;
      overflow_d = 1'b1;
    end else if (push_ok && w_last) begin
      state_d = StIdle;
      done_d  = 1'b1;
    end

    wptr_d = wptr_q + {{PtrW{1'b0}}, push_ok};
    rptr_d = rptr_q + {{PtrW{1'b0}}, pop};
  end

  // Control state, counters and FIFO pointers
  always_ff @(posedge pixclk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      x_q        <= '0;
      y_q        <= '0;
      cnt_q      <= '0;
      pack_q     <= '0;
      psof_q     <= 1'b0;
      first_q    <= 1'b0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      cnt_q      <= cnt_d;
      pack_q     <= pack_d;
      psof_q     <= psof_d;
      first_q    <= first_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
    end
  end

  // FIFO storage: {eol, sof, word}; contents are don't-care until written
  always_ff @(posedge pixclk_i) begin
    if (push_ok) mem_q[wptr_q[PtrW-1:0]] <= {w_eol, w_sof, word};
  end

  assign rd_entry     = mem_q[rptr_q[PtrW-1:0]];
  assign word_valid_o = !empty;
  assign word_o       = empty ? 32'h0 : rd_entry[31:0];
  assign word_sof_o   = !empty && rd_entry[32];
  assign word_eol_o   = !empty && rd_entry[33];
  assign overflow_o   = overflow_q;
  assign frame_done_o = done_q;

endmodule
